// File: rtl/lc3b_types.sv
// Shared LC-3b word/line types plus instruction-cache geometry and FSM encoding.
package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_data;

  localparam int ICACHE_OFFSET_W = 4;
  localparam int ICACHE_INDEX_W  = 3;
  localparam int ICACHE_TAG_W    = 9;
  localparam int ICACHE_LINES    = 1 << ICACHE_INDEX_W;

  typedef enum logic {
    IC_IDLE = 1'b0,
    IC_FILL = 1'b1
  } icache_state_t;
endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: data, tag and valid per line, one write port, combinational read.
module icache_array
  import lc3b_types::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ICACHE_INDEX_W-1:0] w_index,
  input  logic [ICACHE_TAG_W-1:0]   w_tag,
  input  logic [127:0]              w_data,
  input  logic [ICACHE_INDEX_W-1:0] r_index,
  output logic                      r_valid,
  output logic [ICACHE_TAG_W-1:0]   r_tag,
  output logic [127:0]              r_data
);
  logic [ICACHE_LINES-1:0] valid;
  lc3b_data                data_mem [ICACHE_LINES];
  logic [ICACHE_TAG_W-1:0] tag_mem  [ICACHE_LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[w_index] <= 1'b1;
    end
  end

  // Line data and tags are never reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (we) begin
      data_mem[w_index] <= w_data;
      tag_mem[w_index]  <= w_tag;
    end
  end

  assign r_valid = valid[r_index];
  assign r_tag   = tag_mem[r_index];
  // Invalid lines read as zero so uninitialised storage never reaches fetch.
  assign r_data  = r_valid ? data_mem[r_index] : '0;
endmodule

// File: rtl/icache.sv
// Read-only direct-mapped instruction cache: zero-cycle hits, blocking single-line fills.
module icache
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  imem_address,
  input  logic         imem_action_stb,
  input  logic         imem_action_cyc,
  output logic [127:0] imem_rdata,
  output logic         imem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);
  icache_state_t state, state_next;
  lc3b_word      line_addr;
  logic          req;
  logic          hit;
  logic          fill_start;
  logic          fill_done;
  logic          arr_we;
  logic          arr_valid;
  logic [ICACHE_TAG_W-1:0] arr_tag;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  icache_array u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (arr_we),
    .w_index (line_addr[6:4]),
    .w_tag   (line_addr[15:7]),
    .w_data  (pmem_rdata),
    .r_index (imem_address[6:4]),
    .r_valid (arr_valid),
    .r_tag   (arr_tag),
    .r_data  (imem_rdata)
  );

  assign req = imem_action_stb & imem_action_cyc;
  assign hit = (state == IC_IDLE) & req & arr_valid & (arr_tag == imem_address[15:7]);

  always_comb begin
    state_next = state;
    fill_start = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IC_IDLE: begin
        if (req && !hit) begin
          state_next = IC_FILL;
          fill_start = 1'b1;
        end
      end
      IC_FILL: begin
        if (pmem_resp) begin
          state_next = IC_IDLE;
          fill_done  = 1'b1;
        end
      end
      default: state_next = IC_IDLE;
    endcase
  end

  // Reset outranks a completing fill, so an abandoned line is never written.
  assign arr_we       = fill_done & ~rst;
  assign imem_resp    = hit & ~rst;
  assign pmem_read    = (state == IC_FILL);
  assign pmem_address = pmem_read ? line_addr : 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IC_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The fill address is captured once so fetch may wander while memory answers.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_addr <= '0;
    end else if (fill_start) begin
      line_addr <= imem_address & 16'hFFF0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (imem_resp)  hit_count  <= sat_inc(hit_count);
      if (fill_start) miss_count <= sat_inc(miss_count);
    end
  end
endmodule

// File: tb/tb_icache.sv
// Randomised and directed bench for icache against a line-level cache model.
module tb_icache;
  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  imem_address;
  logic         imem_action_stb;
  logic         imem_action_cyc;
  logic [127:0] imem_rdata;
  logic         imem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  always #5 clk = ~clk;

  icache dut (
    .clk             (clk),
    .rst             (rst),
    .imem_address    (imem_address),
    .imem_action_stb (imem_action_stb),
    .imem_action_cyc (imem_action_cyc),
    .imem_rdata      (imem_rdata),
    .imem_resp       (imem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  int checks   = 0;
  int failures = 0;

  // Model: which line address each index currently holds, plus fill bookkeeping.
  bit           m_fill;
  logic [15:0]  m_faddr;
  bit           m_valid [8];
  logic [15:0]  m_line  [8];
  logic [127:0] m_data  [8];
  int           m_hits;
  int           m_miss;

  logic         obs_resp;
  logic [127:0] obs_rdata;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_reset();
    m_fill  = 1'b0;
    m_faddr = '0;
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
  endfunction

  // One clock cycle: drive, check outputs mid-cycle, advance the model, cross the edge.
  task automatic step(input bit r, input bit stb, input bit cyc, input logic [15:0] a,
                      input bit pr, input logic [127:0] pd, input bit chk);
    int  idx;
    bit  req;
    bit  mhit;
    idx = int'(a[6:4]);
    req = stb && cyc;
    rst = r;
    imem_action_stb = stb;
    imem_action_cyc = cyc;
    imem_address = a;
    pmem_resp = pr;
    pmem_rdata = pd;
    #4;
    mhit = !m_fill && req && m_valid[idx] && (m_line[idx] == (a & 16'hFFF0));
    obs_resp  = imem_resp;
    obs_rdata = imem_rdata;
    if (chk) begin
      check("resp", imem_resp, !r && mhit);
      check("pmem_read", pmem_read, m_fill);
      check("pmem_addr", pmem_address, m_fill ? m_faddr : 16'h0);
      check("hit_count", hit_count, m_hits[15:0]);
      check("miss_count", miss_count, m_miss[15:0]);
      check("rdata_known", $isunknown(imem_rdata), 1'b0);
      if (m_valid[idx]) check("rdata", imem_rdata, m_data[idx]);
    end
    if (r) begin
      model_reset();
    end else if (!m_fill) begin
      if (req && mhit) begin
        if (m_hits < 65535) m_hits++;
      end else if (req) begin
        m_fill  = 1'b1;
        m_faddr = a & 16'hFFF0;
        if (m_miss < 65535) m_miss++;
      end
    end else if (pr) begin
      m_valid[int'(m_faddr[6:4])] = 1'b1;
      m_line[int'(m_faddr[6:4])]  = m_faddr;
      m_data[int'(m_faddr[6:4])]  = pd;
      m_fill = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic req_cyc(input logic [15:0] a);
    step(0, 1, 1, a, 0, rand_line(), 1);
  endtask

  task automatic wait_cyc(input logic [15:0] a, input bit stb);
    step(0, stb, 1, a, 0, rand_line(), 1);
  endtask

  task automatic respond(input logic [15:0] a, input logic [127:0] pd);
    step(0, 1, 1, a, 1, pd, 1);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 16'h0, 0, rand_line(), 1);
  endtask

  logic [127:0] line_l;
  logic [127:0] line_m;
  int           lat;
  bit           was_fill;
  bit           r_b, stb_b, cyc_b, pr_b;
  logic [15:0]  a_r;

  initial begin
    rst = 1'b1;
    imem_address = '0;
    imem_action_stb = 1'b0;
    imem_action_cyc = 1'b0;
    pmem_rdata = '0;
    pmem_resp = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("rst_resp", imem_resp, 1'b0);
    check("rst_pread", pmem_read, 1'b0);
    check("rst_paddr", pmem_address, 16'h0);
    check("rst_hits", hit_count, 16'h0);
    check("rst_miss", miss_count, 16'h0);

    // Cold miss, fill after four cycles, then hit the next cycle.
    line_l = rand_line();
    req_cyc(16'h3000);
    check("t33_miss_resp", obs_resp, 1'b0);
    check("t33_pread", pmem_read, 1'b1);
    check("t33_paddr", pmem_address, 16'h3000);
    check("t33_misscnt", miss_count, 16'd1);
    repeat (3) wait_cyc(16'h3000, 1);
    respond(16'h3000, line_l);
    req_cyc(16'h3000);
    check("t33_hit", obs_resp, 1'b1);
    check("t33_line", obs_rdata, line_l);
    req_cyc(16'h300E);
    check("t34_hit", obs_resp, 1'b1);
    check("t34_line", obs_rdata, line_l);
    check("t34_hitcnt", hit_count, 16'd2);

    // Stb without cyc is not a request.
    step(0, 1, 0, 16'h7770, 0, rand_line(), 1);
    check("nocyc_pread", pmem_read, 1'b0);

    // Conflict on index 0.
    line_m = rand_line();
    req_cyc(16'h3080);
    check("t35_miss", obs_resp, 1'b0);
    respond(16'h3080, line_m);
    req_cyc(16'h3080);
    check("t35_hit", obs_rdata, line_m);
    req_cyc(16'h3000);
    check("t35_remiss", obs_resp, 1'b0);
    check("t35_pread", pmem_read, 1'b1);
    respond(16'h3000, line_l);

    // Address wanders during a fill.
    req_cyc(16'h4010);
    repeat (3) wait_cyc(16'h5020, 1);
    check("t36_paddr", pmem_address, 16'h4010);
    respond(16'h5020, rand_line());
    req_cyc(16'h5020);
    check("t36_newmiss", obs_resp, 1'b0);
    check("t36_paddr2", pmem_address, 16'h5020);
    respond(16'h5020, rand_line());
    req_cyc(16'h4010);
    check("t36_4010hit", obs_resp, 1'b1);

    // Reset abandons a fill; late response ignored.
    req_cyc(16'h6000);
    wait_cyc(16'h6000, 0);
    step(1, 0, 0, 16'h6000, 0, rand_line(), 1);
    check("t37_pread_off", pmem_read, 1'b0);
    step(0, 0, 0, 16'h6000, 1, rand_line(), 1);
    req_cyc(16'h6000);
    check("t37_miss", obs_resp, 1'b0);
    check("t37_pread", pmem_read, 1'b1);
    respond(16'h6000, rand_line());

    // Randomised traffic over a small address pool so hits and conflicts are common.
    lat = 0;
    for (int i = 0; i < 3000; i++) begin
      r_b   = ($urandom_range(0, 199) == 0);
      stb_b = ($urandom_range(0, 9) != 0);
      cyc_b = ($urandom_range(0, 9) != 0);
      a_r   = {7'(0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      if (m_fill) begin
        if (lat == 0) pr_b = 1'b1;
        else begin
          pr_b = 1'b0;
          lat--;
        end
      end else begin
        pr_b = ($urandom_range(0, 19) == 0);
      end
      was_fill = m_fill;
      step(r_b, stb_b, cyc_b, a_r, pr_b, rand_line(), 1);
      if (!was_fill && m_fill) lat = $urandom_range(0, 5);
    end
    if (m_fill) respond(16'h0, rand_line());

    // Counter saturation.
    do_reset();
    req_cyc(16'h3000);
    respond(16'h3000, line_l);
    for (int i = 0; i < 65540; i++) step(0, 1, 1, 16'h3004, 0, '0, 0);
    req_cyc(16'h3008);
    check("t38_sat", hit_count, 16'hFFFF);
    check("t38_miss", miss_count, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  reset, synchronous, active-high.
REQ-003: imem_address  input  16  byte address of the requested instruction word from fetch.
REQ-004: imem_action_stb  input  1  request strobe from fetch.
REQ-005: imem_action_cyc  input  1  bus-cycle qualifier; request valid only when stb & cyc.
REQ-006: imem_rdata  output  128  full 16-byte line containing imem_address; fetch selects the word.
REQ-007: imem_resp  output  1  rdata valid for the current imem_address this cycle.
REQ-008: pmem_address  output  16  line-aligned physical address, bits [3:0] = 0.
REQ-009: pmem_read  output  1  line read request to physical memory; held until pmem_resp.
REQ-010: pmem_rdata  input  128  line returned by physical memory.
REQ-011: pmem_resp  input  1  pmem_rdata valid, one-cycle pulse.
REQ-012: hit_count  output  16  saturating count of hit responses.
REQ-013: miss_count  output  16  saturating count of line fills started.

Function
REQ-014: The block SHALL be a direct-mapped, read-only cache of 8 lines x 128 bits: offset [3:0], index [6:4], tag [15:7] (9 bits); each line holds a valid bit.
REQ-015: Request = imem_action_stb & imem_action_cyc; no request -> imem_resp = 0, no state change.
REQ-016: FSM states: IDLE, FILL.
REQ-017: IDLE, request, valid[index] & tag match -> hit: imem_resp = 1 and imem_rdata = line data combinationally in the same cycle (zero-cycle hit latency).
REQ-018: IDLE, request, miss -> imem_resp = 0; latch line address {imem_address[15:4], 4'b0}; next state FILL.
REQ-019: FILL: pmem_read = 1, pmem_address = latched line address, imem_resp = 0, both held stable until pmem_resp.
REQ-020: FILL with pmem_resp = 1 -> write pmem_rdata, latched tag, valid = 1 into latched index at that edge; next state IDLE.
REQ-021: First hit after a fill is the cycle following pmem_resp (miss penalty = pmem latency + 1 cycle).
REQ-022: imem_address changes during FILL SHALL NOT alter the fill; the filled line is the latched one; IDLE then re-evaluates the current address.
REQ-023: pmem_resp received in IDLE SHALL be ignored.
REQ-024: Fill to an occupied index overwrites the previous line (no victim handling; read-only).
REQ-025: imem_rdata outside a hit is don't-care but SHALL be the indexed line data (no X from internal state after reset).
REQ-026: hit_count increments by 1 per cycle with imem_resp = 1; miss_count increments by 1 on each IDLE->FILL transition; both saturate at 16'hFFFF.

Reset
REQ-027: rst = 1 at a clock edge -> state IDLE, all valid bits 0, hit_count = 0, miss_count = 0; line data and tags need not be cleared.
REQ-028: During and after reset outputs SHALL be: imem_resp = 0, pmem_read = 0, pmem_address = 0 while in IDLE.
REQ-029: rst asserted during FILL SHALL abandon the fill: no line written, pmem_read deasserted next cycle; a later pmem_resp is ignored per REQ-023.
REQ-030: rst has priority over pmem_resp in the same cycle.

Structure
REQ-031: lc3b_word (16) and lc3b_data (128) SHALL come from lc3b_types; cache geometry constants (index width 3, tag width 9, offset width 4) and the FSM state enum SHALL be added to lc3b_types.
REQ-032: The block SHALL be split into one datapath sub-module, icache_array (data, tag, valid storage, single write port, combinational read), and the FSM/counters in icache.

Verification
REQ-033: Reset, then request 16'h3000 -> imem_resp = 0, pmem_read = 1, pmem_address = 16'h3000, miss_count = 1; pmem_resp after 4 cycles with line L -> next cycle imem_resp = 1, imem_rdata = L.
REQ-034: After REQ-033, request 16'h300E -> same-cycle hit, imem_rdata = L, hit_count increments.
REQ-035: Conflict: fill 16'h3000 then request 16'h3080 (same index 0, tag differs) -> miss, refill; subsequent 16'h3000 misses again.
REQ-036: During FILL of 16'h4010, change imem_address to 16'h5020 -> pmem_address stays 16'h4010 until pmem_resp; next cycle 16'h5020 misses and starts a new fill.
REQ-037: Assert rst during FILL of 16'h6000, then pulse pmem_resp -> no valid line written; request 16'h6000 misses, pmem_read = 1.
REQ-038: Force 65540 hits -> hit_count holds at 16'hFFFF.
